// File: rtl/gemm_seq_pkg.sv
// Shared types for the GEMM tile sequencer: FSM states, block index and packed slice/tile layouts.
// Widths here mirror the sequencer's default parameters.
package gemm_seq_pkg;

  localparam int IN_W      = 8;
  localparam int OUT_W     = 32;
  localparam int MESH_ROW  = 4;
  localparam int MESH_COL  = 4;
  localparam int TILE_SIZE = 4;
  localparam int BLK_W     = 8;
  localparam int ADDR_W    = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef logic [BLK_W-1:0] blk_idx_t;

  typedef logic [MESH_ROW*TILE_SIZE*IN_W-1:0]  a_slice_t;
  typedef logic [TILE_SIZE*MESH_COL*IN_W-1:0]  b_slice_t;
  typedef logic [MESH_ROW*MESH_COL*OUT_W-1:0]  c_tile_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    c_tile_t           data;
  } c_wr_t;

endpackage

// File: rtl/gemm_seq_addr_gen.sv
// Nested m/n/k block walker (k innermost) producing A/B/C tile-buffer addresses.
// Counts are latched on load; step advances one slice per cycle.
module gemm_seq_addr_gen #(
  parameter int BlkWidth  = 8,
  parameter int AddrWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [BlkWidth-1:0]  m_blk,
  input  logic [BlkWidth-1:0]  n_blk,
  input  logic [BlkWidth-1:0]  k_blk,
  output logic [AddrWidth-1:0] a_addr,
  output logic [AddrWidth-1:0] b_addr,
  output logic [AddrWidth-1:0] c_addr,
  output logic                 first_k,
  output logic                 last_k,
  output logic                 last_blk
);

  localparam logic [BlkWidth-1:0] ONE = BlkWidth'(1);

  logic [BlkWidth-1:0] m_cnt, n_cnt, k_cnt;
  logic [BlkWidth-1:0] m_num, n_num, k_num;
  logic                last_n, last_m;

  assign first_k  = (k_cnt == '0);
  assign last_k   = (k_cnt == k_num - ONE);
  assign last_n   = (n_cnt == n_num - ONE);
  assign last_m   = (m_cnt == m_num - ONE);
  assign last_blk = last_n & last_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_cnt <= '0;
      n_cnt <= '0;
      k_cnt <= '0;
      m_num <= '0;
      n_num <= '0;
      k_num <= '0;
    end else if (load) begin
      m_cnt <= '0;
      n_cnt <= '0;
      k_cnt <= '0;
      m_num <= m_blk;
      n_num <= n_blk;
      k_num <= k_blk;
    end else if (step) begin
      if (last_k) begin
        k_cnt <= '0;
        if (last_n) begin
          n_cnt <= '0;
          m_cnt <= m_cnt + ONE;
        end else begin
          n_cnt <= n_cnt + ONE;
        end
      end else begin
        k_cnt <= k_cnt + ONE;
      end
    end
  end

  // Products are taken at address width so wrap-around is modulo 2^AddrWidth.
  logic [AddrWidth-1:0] m_a, n_a, k_a, kn_a, nn_a;
  assign m_a  = AddrWidth'(m_cnt);
  assign n_a  = AddrWidth'(n_cnt);
  assign k_a  = AddrWidth'(k_cnt);
  assign kn_a = AddrWidth'(k_num);
  assign nn_a = AddrWidth'(n_num);

  assign a_addr = m_a * kn_a + k_a;
  assign b_addr = n_a * kn_a + k_a;
  assign c_addr = m_a * nn_a + n_a;

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Drives the 4x4x4 MAC array over an M x N x K block GEMM: one slice read per cycle, valid 1 cycle later,
// C tile captured MacLatency after the last slice into a 1-deep buffer; DRAIN stalls while it is full. Optional GEMM_SEQ_PERF_EN.
module gemm_tile_sequencer
  import gemm_seq_pkg::*;
#(
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32,
  parameter int meshRow      = 4,
  parameter int meshCol      = 4,
  parameter int tileSize     = 4,
  parameter int BlkWidth     = 8,
  parameter int AddrWidth    = 16,
  parameter int MacLatency   = 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     start_i,
  input  logic [BlkWidth-1:0]                      m_blk_i,
  input  logic [BlkWidth-1:0]                      n_blk_i,
  input  logic [BlkWidth-1:0]                      k_blk_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     a_rd_en_o,
  output logic [AddrWidth-1:0]                     a_rd_addr_o,
  input  logic [meshRow*tileSize*InDataWidth-1:0]  a_rd_data_i,
  output logic                                     b_rd_en_o,
  output logic [AddrWidth-1:0]                     b_rd_addr_o,
  input  logic [tileSize*meshCol*InDataWidth-1:0]  b_rd_data_i,
  output logic [meshRow*tileSize*InDataWidth-1:0]  a_o,
  output logic [tileSize*meshCol*InDataWidth-1:0]  b_o,
  output logic                                     a_valid_o,
  output logic                                     b_valid_o,
  output logic                                     init_save_o,
  output logic                                     acc_clr_o,
  input  logic [meshRow*meshCol*OutDataWidth-1:0]  c_i,
  output logic                                     c_wr_valid_o,
  input  logic                                     c_wr_ready_i,
  output logic [AddrWidth-1:0]                     c_wr_addr_o,
`ifdef GEMM_SEQ_PERF_EN
  output logic [31:0]                              perf_cycles_o,
  output logic [31:0]                              perf_stall_o,
`endif
  output logic [meshRow*meshCol*OutDataWidth-1:0]  c_wr_data_o
);

  localparam int CW  = meshRow*meshCol*OutDataWidth;
  localparam int DCW = $clog2(MacLatency + 2);

  state_t state, state_nxt;

  logic                 issue;
  logic                 start_ok;
  logic                 blk_zero;
  logic                 first_k, last_k, last_blk;
  logic [AddrWidth-1:0] a_addr, b_addr, c_addr;

  logic                 valid_q, init_q, acc_clr_q;
  logic [DCW-1:0]       drain_cnt;
  logic                 drain_ready, capture, c_accept;
  logic                 blk_last_q;
  logic [AddrWidth-1:0] blk_caddr_q;

  logic                 c_full;
  logic [AddrWidth-1:0] c_addr_q;
  logic [CW-1:0]        c_data_q;

  assign start_ok    = (state == IDLE) && start_i;
  assign blk_zero    = (m_blk_i == '0) || (n_blk_i == '0) || (k_blk_i == '0);
  assign drain_ready = (state == DRAIN) && (drain_cnt == DCW'(MacLatency));
  assign c_accept    = c_full && c_wr_ready_i;
  // Capture may coincide with the buffer draining on the same edge.
  assign capture     = drain_ready && (!c_full || c_wr_ready_i);

  gemm_seq_addr_gen #(
    .BlkWidth  (BlkWidth),
    .AddrWidth (AddrWidth)
  ) u_addr_gen (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (start_ok),
    .step     (issue),
    .m_blk    (m_blk_i),
    .n_blk    (n_blk_i),
    .k_blk    (k_blk_i),
    .a_addr   (a_addr),
    .b_addr   (b_addr),
    .c_addr   (c_addr),
    .first_k  (first_k),
    .last_k   (last_k),
    .last_blk (last_blk)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = blk_zero ? DONE : ISSUE;
      ISSUE:   if (last_k) state_nxt = DRAIN;
      DRAIN:   if (capture) state_nxt = blk_last_q ? FLUSH : ISSUE;
      FLUSH:   if (!c_full || c_wr_ready_i) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue  = 1'b0;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state)
      ISSUE: begin
        issue  = 1'b1;
        busy_o = 1'b1;
      end
      DRAIN:   busy_o = 1'b1;
      FLUSH:   busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      init_q      <= 1'b0;
      acc_clr_q   <= 1'b0;
      drain_cnt   <= '0;
      blk_last_q  <= 1'b0;
      blk_caddr_q <= '0;
      c_full      <= 1'b0;
      c_addr_q    <= '0;
    end else begin
      valid_q   <= issue;
      init_q    <= issue && first_k;
      acc_clr_q <= start_ok;
      if (state != DRAIN)   drain_cnt <= '0;
      else if (!drain_ready) drain_cnt <= drain_cnt + DCW'(1);
      // The addr gen moves on to the next block, so remember this block's C slot.
      if (issue && last_k) begin
        blk_last_q  <= last_blk;
        blk_caddr_q <= c_addr;
      end
      if (capture) begin
        c_full   <= 1'b1;
        c_addr_q <= blk_caddr_q;
      end else if (c_accept) begin
        c_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) c_data_q <= c_i;
  end

  assign a_rd_en_o    = issue;
  assign b_rd_en_o    = issue;
  assign a_rd_addr_o  = issue ? a_addr : '0;
  assign b_rd_addr_o  = issue ? b_addr : '0;
  assign a_o          = valid_q ? a_rd_data_i : '0;
  assign b_o          = valid_q ? b_rd_data_i : '0;
  assign a_valid_o    = valid_q;
  assign b_valid_o    = valid_q;
  assign init_save_o  = init_q;
  assign acc_clr_o    = acc_clr_q;
  assign c_wr_valid_o = c_full;
  assign c_wr_addr_o  = c_full ? c_addr_q : '0;
  assign c_wr_data_o  = c_full ? c_data_q : '0;

`ifdef GEMM_SEQ_PERF_EN
  logic stall;
  assign stall = drain_ready && !capture;

  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) begin
      perf_cycles_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (busy_o && (perf_cycles_o != '1)) perf_cycles_o <= perf_cycles_o + 32'd1;
      if (stall && (perf_stall_o != '1))   perf_stall_o  <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Bench for gemm_tile_sequencer: emulates tile SRAMs and the MAC array, and checks writes against a plain GEMM golden.
module tb_gemm_tile_sequencer;
  import gemm_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [7:0]        m_blk_i = '0, n_blk_i = '0, k_blk_i = '0;
  logic              busy_o, done_o;
  logic              a_rd_en_o, b_rd_en_o;
  logic [15:0]       a_rd_addr_o, b_rd_addr_o;
  a_slice_t          a_rd_data_i = '0;
  b_slice_t          b_rd_data_i = '0;
  a_slice_t          a_o;
  b_slice_t          b_o;
  logic              a_valid_o, b_valid_o, init_save_o, acc_clr_o;
  c_tile_t           c_i = '0;
  logic              c_wr_valid_o;
  logic              c_wr_ready_i = 1'b1;
  logic [15:0]       c_wr_addr_o;
  c_tile_t           c_wr_data_o;
`ifdef GEMM_SEQ_PERF_EN
  logic [31:0]       perf_cycles, perf_stall;
`endif

  gemm_tile_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .m_blk_i(m_blk_i), .n_blk_i(n_blk_i), .k_blk_i(k_blk_i),
    .busy_o(busy_o), .done_o(done_o),
    .a_rd_en_o(a_rd_en_o), .a_rd_addr_o(a_rd_addr_o), .a_rd_data_i(a_rd_data_i),
    .b_rd_en_o(b_rd_en_o), .b_rd_addr_o(b_rd_addr_o), .b_rd_data_i(b_rd_data_i),
    .a_o(a_o), .b_o(b_o), .a_valid_o(a_valid_o), .b_valid_o(b_valid_o),
    .init_save_o(init_save_o), .acc_clr_o(acc_clr_o), .c_i(c_i),
    .c_wr_valid_o(c_wr_valid_o), .c_wr_ready_i(c_wr_ready_i), .c_wr_addr_o(c_wr_addr_o),
`ifdef GEMM_SEQ_PERF_EN
    .perf_cycles_o(perf_cycles), .perf_stall_o(perf_stall),
`endif
    .c_wr_data_o(c_wr_data_o)
  );

  a_slice_t a_mem [0:255];
  b_slice_t b_mem [0:255];

  int checks = 0;
  int errors = 0;

  int rd_a_cnt = 0, rd_b_cnt = 0, va_cnt = 0, vb_cnt = 0, init_cnt = 0, wr_total = 0;
  logic [15:0] obs_addr [0:511];
  c_tile_t     obs_data [0:511];
  logic        held = 1'b0;
  logic [15:0] held_addr = '0;
  c_tile_t     held_data = '0;

  typedef struct {
    int m, n, k;
    int fill;       // 0: A all 1, B all 2; 1: random int8
    int rdy;        // 0: always ready, 1: random, 2: low for first 20 cycles
    int poke;       // pulse start_i again while busy
    int exp_wr, exp_rd, exp_init, exp_rd_hold;
  } vec_t;

  function automatic c_tile_t tile_mul(input a_slice_t a, input b_slice_t b);
    c_tile_t t;
    logic signed [7:0]  ea, eb;
    logic signed [31:0] s;
    t = '0;
    for (int r = 0; r < MESH_ROW; r++)
      for (int c = 0; c < MESH_COL; c++) begin
        s = '0;
        for (int kk = 0; kk < TILE_SIZE; kk++) begin
          ea = a[(r*TILE_SIZE+kk)*8 +: 8];
          eb = b[(kk*MESH_COL+c)*8 +: 8];
          s  = s + ea * eb;
        end
        t[(r*MESH_COL+c)*32 +: 32] = s;
      end
    return t;
  endfunction

  function automatic c_tile_t tile_add(input c_tile_t x, input c_tile_t y);
    c_tile_t t;
    for (int i = 0; i < MESH_ROW*MESH_COL; i++) t[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    return t;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Tile SRAMs: one-cycle read latency.
  always @(posedge clk) begin
    if (a_rd_en_o) a_rd_data_i <= a_mem[a_rd_addr_o[7:0]];
    if (b_rd_en_o) b_rd_data_i <= b_mem[b_rd_addr_o[7:0]];
  end

  // MAC array: accumulate every valid slice, restart on init_save; result visible after the edge.
  always @(posedge clk) begin
    if (a_valid_o && b_valid_o)
      c_i <= tile_add(init_save_o ? c_tile_t'('0) : c_i, tile_mul(a_o, b_o));
  end

  always @(posedge clk) begin
    if (a_rd_en_o) rd_a_cnt++;
    if (b_rd_en_o) rd_b_cnt++;
    if (a_valid_o) va_cnt++;
    if (b_valid_o) vb_cnt++;
    if (a_valid_o && init_save_o) init_cnt++;
    if (held) begin
      checks++;
      if (!c_wr_valid_o || c_wr_addr_o !== held_addr || c_wr_data_o !== held_data) begin
        errors++;
        $display("FAIL c_wr_hold actual=%0b/%0h expected=1/%0h", c_wr_valid_o, c_wr_addr_o, held_addr);
      end
    end
    if (c_wr_valid_o && c_wr_ready_i && wr_total < 512) begin
      obs_addr[wr_total] = c_wr_addr_o;
      obs_data[wr_total] = c_wr_data_o;
      wr_total++;
    end
    held      = c_wr_valid_o && !c_wr_ready_i && !rst_i;
    held_addr = c_wr_addr_o;
    held_data = c_wr_data_o;
  end

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 256; i++) begin
      if (mode == 0) begin
        a_mem[i] = {16{8'h01}};
        b_mem[i] = {16{8'h02}};
      end else begin
        a_mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        b_mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctrl"}, {busy_o, done_o, a_rd_en_o, b_rd_en_o, a_valid_o, b_valid_o,
                         init_save_o, acc_clr_o, c_wr_valid_o}, '0);
    chk({tag, "_addr"}, {a_rd_addr_o, b_rd_addr_o, c_wr_addr_o}, '0);
    chk({tag, "_ab"}, {a_o, b_o}, '0);
    chk({tag, "_cdata"}, c_wr_data_o, '0);
  endtask

  task automatic run_job(input vec_t v);
    logic [15:0] exp_addr [0:63];
    c_tile_t     exp_data [0:63];
    c_tile_t     acc;
    int nb, idx, cyc, wr0, rda0, rdb0, va0, vb0, is0;
    nb  = (v.m > 0 && v.n > 0 && v.k > 0) ? v.m * v.n : 0;
    fill_mem(v.fill);
    idx = 0;
    if (nb > 0)
      for (int mi = 0; mi < v.m; mi++)
        for (int ni = 0; ni < v.n; ni++) begin
          acc = '0;
          for (int ki = 0; ki < v.k; ki++)
            acc = tile_add(acc, tile_mul(a_mem[mi*v.k+ki], b_mem[ni*v.k+ki]));
          exp_addr[idx] = 16'(mi * v.n + ni);
          exp_data[idx] = acc;
          idx++;
        end
    wr0 = wr_total; rda0 = rd_a_cnt; rdb0 = rd_b_cnt; va0 = va_cnt; vb0 = vb_cnt; is0 = init_cnt;

    @(negedge clk);
    start_i = 1'b1;
    m_blk_i = 8'(v.m); n_blk_i = 8'(v.n); k_blk_i = 8'(v.k);
    c_wr_ready_i = (v.rdy != 2);
    @(negedge clk);
    start_i = 1'b0;
    chk("acc_clr_pulse", acc_clr_o, 1);
    cyc = 0;
    while (!done_o && cyc < 4000) begin
      case (v.rdy)
        0:       c_wr_ready_i = 1'b1;
        1:       c_wr_ready_i = 1'($urandom_range(0, 1));
        default: c_wr_ready_i = (cyc >= 20);
      endcase
      if (v.poke != 0 && cyc == 3) begin
        start_i = 1'b1; m_blk_i = 8'd3; n_blk_i = 8'd3; k_blk_i = 8'd3;
      end
      if (v.poke != 0 && cyc == 4) begin
        start_i = 1'b0; m_blk_i = 8'(v.m); n_blk_i = 8'(v.n); k_blk_i = 8'(v.k);
      end
      if (v.rdy == 2 && cyc == 18) begin
        chk("drain_stall_reads", rd_a_cnt - rda0, v.exp_rd_hold);
        chk("drain_stall_valid_low", a_valid_o, 0);
        chk("drain_stall_wr_pending", c_wr_valid_o, 1);
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done_o, 1);
    if (nb == 0) chk("done_next_cycle", cyc, 0);
    c_wr_ready_i = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", {busy_o, done_o}, 0);
    chk("wr_count", wr_total - wr0, v.exp_wr);
    chk("rd_a_count", rd_a_cnt - rda0, v.exp_rd);
    chk("rd_b_count", rd_b_cnt - rdb0, v.exp_rd);
    chk("valid_a_count", va_cnt - va0, v.exp_rd);
    chk("valid_b_count", vb_cnt - vb0, v.exp_rd);
    chk("init_save_count", init_cnt - is0, v.exp_init);
    for (int i = 0; i < nb; i++) begin
      chk("c_wr_addr", obs_addr[wr0+i], exp_addr[i]);
      chk("c_wr_data", obs_data[wr0+i], exp_data[i]);
    end
    repeat (3) @(negedge clk);
    chk("no_extra_writes", wr_total - wr0, v.exp_wr);
  endtask

  vec_t    vecs [7];
  vec_t    rv;
  c_tile_t eights;

  initial begin
    //            m  n  k  fill rdy poke wr  rd  init hold
    vecs[0] = '{1, 1, 1,  0,  0,  0,  1,  1,  1,  0};
    vecs[1] = '{1, 4, 16, 1,  0,  0,  4,  64, 4,  0};
    vecs[2] = '{1, 1, 0,  1,  0,  0,  0,  0,  0,  0};
    vecs[3] = '{2, 2, 4,  1,  2,  0,  4,  16, 4,  8};
    vecs[4] = '{1, 2, 3,  1,  0,  1,  2,  6,  2,  0};
    vecs[5] = '{3, 2, 5,  1,  1,  0,  6,  30, 6,  0};
    vecs[6] = '{0, 3, 3,  1,  0,  0,  0,  0,  0,  0};
    for (int i = 0; i < MESH_ROW*MESH_COL; i++) eights[i*32 +: 32] = 32'd8;

    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i]);
      if (i == 0) chk("c_all_eight", obs_data[wr_total-1], eights);
    end

    for (int r = 0; r < 6; r++) begin
      rv.m = $urandom_range(1, 3); rv.n = $urandom_range(1, 3); rv.k = $urandom_range(1, 6);
      rv.fill = 1; rv.rdy = 1; rv.poke = 0; rv.exp_rd_hold = 0;
      rv.exp_wr = rv.m * rv.n; rv.exp_rd = rv.m * rv.n * rv.k; rv.exp_init = rv.m * rv.n;
      run_job(rv);
    end

    // Reset in the middle of ISSUE, then a clean 1x1x1 job.
    fill_mem(1);
    @(negedge clk);
    start_i = 1'b1; m_blk_i = 8'd2; n_blk_i = 8'd2; k_blk_i = 8'd4;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("mid_issue_rd_en", a_rd_en_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    chk_outputs_zero("mid_reset");
    rst_i = 1'b0;
    run_job(vecs[0]);
    chk("restart_c_all_eight", obs_data[wr_total-1], eights);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
